// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick-breaker game sequencer.
package brick_game_pkg;

  typedef enum logic [2:0] {
    StAttract    = 3'd0,
    StServe      = 3'd1,
    StPlay       = 3'd2,
    StPause      = 3'd3,
    StLifeLost   = 3'd4,
    StLevelClear = 3'd5,
    StGameOver   = 3'd6
  } state_e;

  localparam logic [1:0] OV_NONE   = 2'd0;
  localparam logic [1:0] OV_LOGO   = 2'd1;
  localparam logic [1:0] OV_PAUSED = 2'd2;
  localparam logic [1:0] OV_FAIL   = 2'd3;

  localparam int unsigned DefLivesInit   = 3;
  localparam int unsigned DefServeFrames = 60;
  localparam int unsigned DefLostFrames  = 90;
  localparam int unsigned DefClearFrames = 120;
  localparam int unsigned DefMaxLevel    = 7;
  localparam int unsigned DefTimerW      = 8;

endpackage

// File: rtl/frame_timer.sv
// Frame-rate down-counter: loads on state entry, counts frame ticks, flags expiry at zero.
module frame_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  input  logic               tick_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && tick_i && (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Brick-breaker game sequencer: state, lives, level and frame delays with registered outputs.
module game_flow_ctrl
  import brick_game_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = DefLivesInit,
  parameter int unsigned SERVE_FRAMES = DefServeFrames,
  parameter int unsigned LOST_FRAMES  = DefLostFrames,
  parameter int unsigned CLEAR_FRAMES = DefClearFrames,
  parameter int unsigned MAX_LEVEL    = DefMaxLevel,
  parameter int unsigned TIMER_W      = DefTimerW
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iFrame_Tick,
  input  logic       iStart,
  input  logic       iRun,
  input  logic       iBottom_Hit,
  input  logic [7:0] iBricks_Left,
  output logic [2:0] oState,
  output logic       oBall_Run,
  output logic       oBall_Serve,
  output logic       oBrick_Reload,
  output logic [1:0] oOverlay,
  output logic [3:0] oLives,
  output logic [2:0] oLevel
);

  state_e             state_d, state_q;
  logic [3:0]         lives_d, lives_q;
  logic [2:0]         level_d, level_q;
  logic               run_d, run_q;
  logic               serve_d, serve_q;
  logic               reload_d, reload_q;
  logic [1:0]         overlay_d, overlay_q;
  logic               entry_d, entry_q;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               expire;

  // Timer only runs in the states that own a frame delay.
  assign tmr_en = (state_q == StServe) || (state_q == StLifeLost) || (state_q == StLevelClear);

  frame_timer #(
    .TIMER_W (TIMER_W)
  ) u_frame_timer (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tick_i     (iFrame_Tick),
    .expire_o   (expire)
  );

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    level_d  = level_q;
    serve_d  = 1'b0;
    reload_d = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StAttract: begin
        if (iStart) begin
          state_d  = StServe;
          lives_d  = 4'(LIVES_INIT);
          level_d  = '0;
          reload_d = 1'b1;
          serve_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SERVE_FRAMES);
        end
      end
      StServe: begin
        // A launch press in the entry cycle is the same press that started the serve.
        if ((iStart && !entry_q) || expire) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // Brick count is stale for one cycle after a reload, so skip it on entry.
        if (!entry_q && (iBricks_Left == 8'd0)) begin
          state_d  = StLevelClear;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(CLEAR_FRAMES);
        end else if (iBottom_Hit) begin
          if (lives_q <= 4'd1) begin
            lives_d = '0;
            state_d = StGameOver;
          end else begin
            lives_d  = lives_q - 4'd1;
            state_d  = StLifeLost;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(LOST_FRAMES);
          end
        end else if (!iRun) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (iRun) begin
          state_d = StPlay;
        end
      end
      StLifeLost: begin
        if (expire) begin
          state_d  = StServe;
          serve_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SERVE_FRAMES);
        end
      end
      StLevelClear: begin
        if (expire) begin
          level_d  = (level_q >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level_q + 3'd1;
          state_d  = StServe;
          reload_d = 1'b1;
          serve_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SERVE_FRAMES);
        end
      end
      StGameOver: begin
        lives_d = '0;
        if (iStart) begin
          state_d = StAttract;
        end
      end
      default: begin
        state_d = StAttract;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land together with oState.
  always_comb begin
    entry_d   = (state_d != state_q);
    run_d     = (state_d == StPlay);
    overlay_d = OV_NONE;
    unique case (state_d)
      StAttract:  overlay_d = OV_LOGO;
      StPause:    overlay_d = OV_PAUSED;
      StGameOver: overlay_d = OV_FAIL;
      default:    overlay_d = OV_NONE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StAttract;
      lives_q   <= 4'(LIVES_INIT);
      level_q   <= '0;
      run_q     <= 1'b0;
      serve_q   <= 1'b0;
      reload_q  <= 1'b0;
      overlay_q <= OV_LOGO;
      entry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      run_q     <= run_d;
      serve_q   <= serve_d;
      reload_q  <= reload_d;
      overlay_q <= overlay_d;
      entry_q   <= entry_d;
    end
  end

  assign oState        = state_q;
  assign oBall_Run     = run_q;
  assign oBall_Serve   = serve_q;
  assign oBrick_Reload = reload_q;
  assign oOverlay      = overlay_q;
  assign oLives        = lives_q;
  assign oLevel        = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

  localparam logic [2:0] S_ATTRACT = 3'd0;
  localparam logic [2:0] S_SERVE   = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_LOST    = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       run = 1'b1;
  logic       bottom = 1'b0;
  logic [7:0] bricks = 8'd50;
  logic [2:0] state;
  logic       ball_run, ball_serve, reload;
  logic [1:0] overlay;
  logic [3:0] lives;
  logic [2:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iFrame_Tick   (tick),
    .iStart        (start),
    .iRun          (run),
    .iBottom_Hit   (bottom),
    .iBricks_Left  (bricks),
    .oState        (state),
    .oBall_Run     (ball_run),
    .oBall_Serve   (ball_serve),
    .oBrick_Reload (reload),
    .oOverlay      (overlay),
    .oLives        (lives),
    .oLevel        (level)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_bottom();
    bottom = 1'b1;
    step();
    bottom = 1'b0;
  endtask

  // Launch from SERVE after its entry cycle has passed; lands in the first PLAY cycle.
  task automatic launch();
    step();
    pulse_start();
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL launch state got %0d want %0d", state, S_PLAY); end
    tests++; if (ball_run !== 1'b1) begin fails++; $display("FAIL launch run got %0b want 1", ball_run); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests++; if (state !== S_ATTRACT) begin fails++; $display("FAIL rst_state got %0d want 0", state); end
    tests++; if (lives !== 4'd3) begin fails++; $display("FAIL rst_lives got %0d want 3", lives); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL rst_level got %0d want 0", level); end
    tests++; if (overlay !== 2'd1) begin fails++; $display("FAIL rst_overlay got %0d want 1", overlay); end
    tests++; if ({ball_run, ball_serve, reload} !== 3'b000) begin fails++; $display("FAIL rst_pulses got %b want 000", {ball_run, ball_serve, reload}); end
    rst = 1'b0;
    step();
    tests++; if (state !== S_ATTRACT) begin fails++; $display("FAIL idle_state got %0d want 0", state); end
  endtask

  task automatic test_new_game();
    pulse_start();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL ng_state got %0d want 1", state); end
    tests++; if ({reload, ball_serve} !== 2'b11) begin fails++; $display("FAIL ng_pulses got %b want 11", {reload, ball_serve}); end
    tests++; if (lives !== 4'd3) begin fails++; $display("FAIL ng_lives got %0d want 3", lives); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL ng_level got %0d want 0", level); end
    tests++; if (overlay !== 2'd0) begin fails++; $display("FAIL ng_overlay got %0d want 0", overlay); end
    // Start pressed in the serve entry cycle must be ignored.
    pulse_start();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL ng_entry_start got %0d want 1", state); end
    tests++; if ({reload, ball_serve} !== 2'b00) begin fails++; $display("FAIL ng_pulse_width got %b want 00", {reload, ball_serve}); end
  endtask

  task automatic test_serve_timeout();
    ticks(60);
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL srv_60 got %0d want 1", state); end
    tests++; if (ball_run !== 1'b0) begin fails++; $display("FAIL srv_run got %0b want 0", ball_run); end
    ticks(1);
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL srv_61 got %0d want 2", state); end
    tests++; if (ball_run !== 1'b1) begin fails++; $display("FAIL srv_play_run got %0b want 1", ball_run); end
  endtask

  task automatic test_life_lost(input logic [3:0] exp_lives);
    step();
    pulse_bottom();
    tests++; if (state !== S_LOST) begin fails++; $display("FAIL ll_state got %0d want 4", state); end
    tests++; if (lives !== exp_lives) begin fails++; $display("FAIL ll_lives got %0d want %0d", lives, exp_lives); end
    tests++; if (ball_run !== 1'b0) begin fails++; $display("FAIL ll_run got %0b want 0", ball_run); end
    ticks(90);
    tests++; if (state !== S_LOST) begin fails++; $display("FAIL ll_90 got %0d want 4", state); end
    ticks(1);
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL ll_91 got %0d want 1", state); end
    tests++; if ({ball_serve, reload} !== 2'b10) begin fails++; $display("FAIL ll_pulses got %b want 10", {ball_serve, reload}); end
    step();
    tests++; if (ball_serve !== 1'b0) begin fails++; $display("FAIL ll_serve_width got %0b want 0", ball_serve); end
  endtask

  task automatic test_pause();
    step();
    run = 1'b0;
    step();
    tests++; if (state !== S_PAUSE) begin fails++; $display("FAIL pz_state got %0d want 3", state); end
    tests++; if (overlay !== 2'd2) begin fails++; $display("FAIL pz_overlay got %0d want 2", overlay); end
    tests++; if (ball_run !== 1'b0) begin fails++; $display("FAIL pz_run got %0b want 0", ball_run); end
    ticks(3);
    pulse_bottom();
    pulse_start();
    tests++; if (state !== S_PAUSE) begin fails++; $display("FAIL pz_hold got %0d want 3", state); end
    tests++; if (lives !== 4'd2) begin fails++; $display("FAIL pz_lives got %0d want 2", lives); end
    run = 1'b1;
    step();
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL pz_resume got %0d want 2", state); end
    tests++; if ({ball_serve, reload} !== 2'b00) begin fails++; $display("FAIL pz_no_serve got %b want 00", {ball_serve, reload}); end
    tests++; if (overlay !== 2'd0) begin fails++; $display("FAIL pz_ov_none got %0d want 0", overlay); end
  endtask

  // Called in the first PLAY cycle with lives==1.
  task automatic test_clear_priority();
    bricks = 8'd0;
    step();
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL cp_entry_skip got %0d want 2", state); end
    bottom = 1'b1;
    step();
    bottom = 1'b0;
    tests++; if (state !== S_CLEAR) begin fails++; $display("FAIL cp_state got %0d want 5", state); end
    tests++; if (lives !== 4'd1) begin fails++; $display("FAIL cp_lives got %0d want 1", lives); end
  endtask

  task automatic test_level_saturation();
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] exp_lvl;
      exp_lvl = (k > 7) ? 3'd7 : 3'(k);
      ticks(120);
      tests++; if (state !== S_CLEAR) begin fails++; $display("FAIL lv%0d_hold got %0d want 5", k, state); end
      ticks(1);
      tests++; if (state !== S_SERVE) begin fails++; $display("FAIL lv%0d_state got %0d want 1", k, state); end
      tests++; if (level !== exp_lvl) begin fails++; $display("FAIL lv%0d_level got %0d want %0d", k, level, exp_lvl); end
      tests++; if ({reload, ball_serve} !== 2'b11) begin fails++; $display("FAIL lv%0d_pulses got %b want 11", k, {reload, ball_serve}); end
      bricks = 8'd50;
      if (k < 8) begin
        launch();
        step();
        bricks = 8'd0;
        step();
        tests++; if (state !== S_CLEAR) begin fails++; $display("FAIL lv%0d_clear got %0d want 5", k, state); end
      end
    end
  endtask

  task automatic test_game_over();
    launch();
    step();
    pulse_bottom();
    tests++; if (state !== S_OVER) begin fails++; $display("FAIL go_state got %0d want 6", state); end
    tests++; if (overlay !== 2'd3) begin fails++; $display("FAIL go_overlay got %0d want 3", overlay); end
    tests++; if (lives !== 4'd0) begin fails++; $display("FAIL go_lives got %0d want 0", lives); end
    tests++; if (ball_run !== 1'b0) begin fails++; $display("FAIL go_run got %0b want 0", ball_run); end
    step();
    tests++; if (lives !== 4'd0) begin fails++; $display("FAIL go_lives_hold got %0d want 0", lives); end
    pulse_start();
    tests++; if (state !== S_ATTRACT) begin fails++; $display("FAIL go_attract got %0d want 0", state); end
    tests++; if (overlay !== 2'd1) begin fails++; $display("FAIL go_logo got %0d want 1", overlay); end
  endtask

  task automatic test_reset_mid_lost();
    pulse_start();
    tests++; if (lives !== 4'd3) begin fails++; $display("FAIL rm_newgame_lives got %0d want 3", lives); end
    launch();
    step();
    pulse_bottom();
    tests++; if (state !== S_LOST) begin fails++; $display("FAIL rm_lost got %0d want 4", state); end
    ticks(5);
    #2 rst = 1'b1;
    #1;
    tests++; if (state !== S_ATTRACT) begin fails++; $display("FAIL rm_state got %0d want 0", state); end
    tests++; if (lives !== 4'd3) begin fails++; $display("FAIL rm_lives got %0d want 3", lives); end
    tests++; if ({ball_run, ball_serve, reload} !== 3'b000) begin fails++; $display("FAIL rm_pulses got %b want 000", {ball_run, ball_serve, reload}); end
    tests++; if (overlay !== 2'd1) begin fails++; $display("FAIL rm_overlay got %0d want 1", overlay); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_new_game();
    test_serve_timeout();
    test_life_lost(4'd2);
    launch();
    test_pause();
    test_life_lost(4'd1);
    launch();
    test_clear_priority();
    test_level_saturation();
    test_game_over();
    test_reset_mid_lost();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the brick-breaker datapath. It owns the game state (attract, serve, play, pause, life-lost, level-clear, game-over), the lives and level counters, and the frame-based delay timers. It drives ball run/serve, brick-wall reload and the overlay select consumed by the colour mux, replacing the raw switch- and bottom-hit-driven sequencing of the paddle, ball, bricks and lives blocks.

Parameters:
LIVES_INIT, 3, lives loaded at new game (1..15)
SERVE_FRAMES, 60, frames the ball waits on the paddle before auto-launch
LOST_FRAMES, 90, frames spent in LIFE_LOST before re-serve
CLEAR_FRAMES, 120, frames spent in LEVEL_CLEAR before next level
MAX_LEVEL, 7, saturating level ceiling (fits oLevel)
TIMER_W, 8, frame timer width; all *_FRAMES < 2**TIMER_W

Ports:
iCLK  in  1  pixel/system clock
iRST  in  1  asynchronous, active-high reset
iFrame_Tick  in  1  one-cycle pulse per frame (end of active video)
iStart  in  1  one-cycle start/launch pulse (debounced key or PS2 space)
iRun  in  1  level; 1 = run, 0 = pause request
iBottom_Hit  in  1  one-cycle pulse: ball left the playfield bottom
iBricks_Left  in  8  remaining brick count from brick tracker
oState  out  3  current state encoding (package enum)
oBall_Run  out  1  1 = ball integrates motion
oBall_Serve  out  1  one-cycle pulse: park ball on paddle, reset velocity
oBrick_Reload  out  1  one-cycle pulse: restore full brick wall
oOverlay  out  2  0 none, 1 LOGO, 2 PAUSED, 3 FAIL
oLives  out  4  remaining lives
oLevel  out  3  current level, 0-based; ball speed select

Behaviour:
- Reset (async, iRST=1): state ATTRACT, timer 0, oLives=LIVES_INIT, oLevel=0, oBall_Run=0, oBall_Serve=0, oBrick_Reload=0, oOverlay=LOGO. All outputs registered; a state change is visible one cycle after the causing input.
- Timer: loaded on state entry with the state's *_FRAMES value; decrements only on iFrame_Tick; "expire" = iFrame_Tick while timer==0. Holds in states without timers.
- ATTRACT: overlay LOGO, ball stopped. iStart -> SERVE; same edge: lives<=LIVES_INIT, level<=0, pulse oBrick_Reload and oBall_Serve, timer<=SERVE_FRAMES.
- SERVE: oBall_Run=0, overlay none. iStart or expire -> PLAY. iStart is ignored in the first cycle after entry.
- PLAY: oBall_Run=1. Evaluation order per cycle:
  1) iBricks_Left==0 -> LEVEL_CLEAR, timer<=CLEAR_FRAMES. This wins over a simultaneous iBottom_Hit (no life lost).
  2) iBottom_Hit: if lives==1 -> lives<=0, GAME_OVER; else lives<=lives-1, LIFE_LOST, timer<=LOST_FRAMES.
  3) iRun==0 -> PAUSE.
  iBricks_Left is not checked in the first PLAY cycle (covers reload latency).
- PAUSE: oBall_Run=0, overlay PAUSED, timer frozen, iBottom_Hit/iStart ignored. iRun==1 -> PLAY; no serve pulse, ball resumes in place.
- LIFE_LOST: oBall_Run=0. Expire -> SERVE with oBall_Serve pulse, timer<=SERVE_FRAMES.
- LEVEL_CLEAR: oBall_Run=0. Expire -> level<=min(level+1, MAX_LEVEL), pulse oBrick_Reload and oBall_Serve, -> SERVE.
- GAME_OVER: overlay FAIL, oBall_Run=0, lives held at 0. iStart -> ATTRACT.
- iRun==0 in SERVE, LIFE_LOST or LEVEL_CLEAR is honoured only once PLAY is reached.
- Lives never underflow and never exceed LIVES_INIT.
- Pulses are exactly one cycle wide and never asserted in the same cycle as reset.
- Illegal state encoding -> ATTRACT.

Decomposition:
- brick_game_pkg holds:
  - state enum (ATTRACT, SERVE, PLAY, PAUSE, LIFE_LOST, LEVEL_CLEAR, GAME_OVER)
  - overlay codes (OV_NONE, OV_LOGO, OV_PAUSED, OV_FAIL)
  - default frame constants
- One sub-module, frame_timer: load/value/tick/expire; TIMER_W-wide down-counter with async reset.

Test Plan:
- Reset, then iStart -> next cycle oState=SERVE, oBrick_Reload=1 and oBall_Serve=1 for one cycle, oLives=3, oLevel=0.
- In SERVE, drive 61 frame ticks with no iStart -> PLAY on the 61st tick (timer 60..0 then expire), oBall_Run=1.
- In PLAY with lives=3, pulse iBottom_Hit -> LIFE_LOST, oLives=2; after 91 ticks -> SERVE with one oBall_Serve pulse.
- In PLAY with lives=1, drive iBottom_Hit and iBricks_Left=0 in the same cycle -> LEVEL_CLEAR, oLives stays 1. After 121 ticks -> oLevel=1, reload and serve pulses. Repeat to level 7; the next clear keeps oLevel=7.
- In PLAY, drop iRun -> PAUSE, oOverlay=2. Frame ticks and iBottom_Hit pulses are ignored (lives unchanged). Raise iRun -> PLAY with no serve pulse.
- In PLAY with lives=1, pulse iBottom_Hit -> GAME_OVER, oOverlay=3, oLives=0. iStart -> ATTRACT, oOverlay=1. Assert iRst mid-LIFE_LOST -> immediate ATTRACT, lives=3, all pulses 0.
